// File: rtl/reg_file_pkg.sv
// Core-wide register file constants shared with the decoder and writeback mux.
package reg_file_pkg;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int CORE_BUS_WIDTH = 32;
   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: x0 forced to zero, optional write-data forwarding.
module reg_file_read_port
   import reg_file_pkg::*;
#(
   parameter int BUS_WIDTH  = CORE_BUS_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int NREGS      = 2**ADDR_WIDTH
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  byp_en,
   input  logic [ADDR_WIDTH-1:0] byp_addr,
   input  logic [BUS_WIDTH-1:0]  byp_data,
   input  logic [BUS_WIDTH-1:0]  regs [1:NREGS-1],
   output logic [BUS_WIDTH-1:0]  data
);
   always_comb begin
      data = '0;
      if (addr != ADDR_WIDTH'(ZERO_REG)) begin
         // byp_en already excludes x0 and reset, so only the index compare is needed here
         if (byp_en && (byp_addr == addr)) data = byp_data;
         else                              data = regs[addr];
      end
   end
endmodule

// File: rtl/reg_file.sv
// Architectural integer register file: two ALU read ports, one write port, one debug port.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int BUS_WIDTH  = CORE_BUS_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [BUS_WIDTH-1:0]  rd_data_a,
   output logic [BUS_WIDTH-1:0]  rd_data_b,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [BUS_WIDTH-1:0]  wr_data,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [BUS_WIDTH-1:0]  dbg_data
);
   localparam int NREGS = 2**ADDR_WIDTH;
   localparam int NRP   = 2;

   logic [BUS_WIDTH-1:0] regs [1:NREGS-1];
   logic                 wr_live;
   logic                 byp_en;

   logic [NRP-1:0][ADDR_WIDTH-1:0] rp_addr;
   logic [NRP-1:0][BUS_WIDTH-1:0]  rp_data;

   assign wr_live = wr_en && (wr_addr != ADDR_WIDTH'(ZERO_REG));
   assign byp_en  = BYPASS && wr_live && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rp_addr   = {rd_addr_b, rd_addr_a};
   assign rd_data_a = rp_data[0];
   assign rd_data_b = rp_data[1];

   for (genvar p = 0; p < NRP; p++) begin : g_rp
      reg_file_read_port #(
         .BUS_WIDTH (BUS_WIDTH),
         .ADDR_WIDTH(ADDR_WIDTH)
      ) u_rp (
         .addr    (rp_addr[p]),
         .byp_en  (byp_en),
         .byp_addr(wr_addr),
         .byp_data(wr_data),
         .regs    (regs),
         .data    (rp_data[p])
      );
   end

   // Debug view is the stored state only, so forwarding is tied off
   reg_file_read_port #(
      .BUS_WIDTH (BUS_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_dbg (
      .addr    (dbg_addr),
      .byp_en  (1'b0),
      .byp_addr('0),
      .byp_data('0),
      .regs    (regs),
      .data    (dbg_data)
   );

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && wr_en) assert (!$isunknown(wr_addr));
   end
`endif
endmodule

// File: tb/tb_reg_file.sv
// Directed checks of reg_file with forwarding enabled (u_byp) and disabled (u_nob).
module tb_reg_file;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, dbg_addr;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [31:0] a1, b1, d1, a0, b0, d0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file #(.BUS_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) u_byp (
      .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(a1), .rd_data_b(b1), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(d1));

   reg_file #(.BUS_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) u_nob (
      .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(a0), .rd_data_b(b0), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(d0));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
      rd_addr_a = a; rd_addr_b = b; dbg_addr = d;
   endtask

   task automatic wr(input logic en, input logic [4:0] ad, input logic [31:0] dat);
      wr_en = en; wr_addr = ad; wr_data = dat;
   endtask

   // Apply one write on the next rising edge, then idle the write port
   task automatic do_write(input logic [4:0] ad, input logic [31:0] dat);
      @(negedge clk);
      wr(1'b1, ad, dat);
      @(posedge clk); #1;
      wr(1'b0, 5'd0, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      rd(5'd0, 5'd0, 5'd0);
      wr(1'b0, 5'd0, 32'h0);

      // 1. reset: every index reads 0, even with a write (and bypass) requested
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rd(5'(i), 5'(31 - i), 5'(i));
         wr(1'b1, 5'(i), 32'hFFFF_0000 | i);
         #1;
         chk($sformatf("rst_a%0d", i), a1, 32'h0);
         chk($sformatf("rst_b%0d", i), b1, 32'h0);
         chk($sformatf("rst_dbg%0d", i), d1, 32'h0);
         chk($sformatf("rst_nob_a%0d", i), a0, 32'h0);
      end
      @(negedge clk);
      wr(1'b0, 5'd0, 32'h0);
      rst_n = 1'b1;
      rd(5'd31, 5'd31, 5'd31);
      @(posedge clk); #1;
      chk("post_rst_x31_a", a1, 32'h0);
      chk("post_rst_x31_dbg", d0, 32'h0);

      // 2. write/read
      do_write(5'd5, 32'hDEAD_BEEF);
      rd(5'd5, 5'd0, 5'd5);
      #1;
      chk("wr5_a_byp", a1, 32'hDEAD_BEEF);
      chk("wr5_a_nob", a0, 32'hDEAD_BEEF);
      chk("wr5_dbg",   d1, 32'hDEAD_BEEF);
      chk("wr5_b0",    b1, 32'h0);

      // 3. x0 never stored, never forwarded
      @(negedge clk);
      rd(5'd0, 5'd0, 5'd0);
      wr(1'b1, 5'd0, 32'hFFFF_FFFF);
      #1;
      chk("x0_byp_a_pre", a1, 32'h0);
      chk("x0_byp_b_pre", b1, 32'h0);
      @(posedge clk); #1;
      wr(1'b0, 5'd0, 32'h0);
      chk("x0_a",   a1, 32'h0);
      chk("x0_b",   b0, 32'h0);
      chk("x0_dbg", d1, 32'h0);

      // 4. bypass vs. stored read
      do_write(5'd7, 32'h1);
      @(negedge clk);
      rd(5'd7, 5'd7, 5'd7);
      wr(1'b1, 5'd7, 32'h12);
      #1;
      chk("byp_a",     a1, 32'h12);
      chk("byp_b",     b1, 32'h12);
      chk("byp_dbg",   d1, 32'h1);
      chk("nob_a_old", a0, 32'h1);
      chk("nob_b_old", b0, 32'h1);
      chk("nob_dbg",   d0, 32'h1);
      rd(5'd7, 5'd5, 5'd7);
      #1;
      chk("byp_b_other", b1, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      wr(1'b0, 5'd0, 32'h0);
      chk("nob_a_new", a0, 32'h12);
      chk("nob_dbg_new", d0, 32'h12);

      // 5. wr_en gating
      do_write(5'd9, 32'h3);
      @(negedge clk);
      rd(5'd9, 5'd9, 5'd9);
      wr(1'b0, 5'd9, 32'hA5A5_A5A5);
      #1;
      chk("gate_no_byp", a1, 32'h3);
      @(posedge clk); #1;
      chk("gate_a", a1, 32'h3);
      chk("gate_dbg", d0, 32'h3);

      // 6. reset mid-cycle overrides a pending write
      do_write(5'd3, 32'h55);
      rd(5'd3, 5'd9, 5'd3);
      #1;
      chk("r3_pre", a0, 32'h55);
      @(negedge clk);
      wr(1'b1, 5'd3, 32'h77);
      #1;
      chk("r3_byp_pre_rst", a1, 32'h77);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_a_byp", a1, 32'h0);
      chk("midrst_a_nob", a0, 32'h0);
      chk("midrst_b9",    b1, 32'h0);
      chk("midrst_dbg",   d1, 32'h0);
      @(posedge clk); #1;
      chk("midrst_edge", a0, 32'h0);
      @(negedge clk);
      wr(1'b0, 5'd3, 32'h77);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rel_a",   a1, 32'h0);
      chk("post_rel_dbg", d0, 32'h0);
      do_write(5'd3, 32'h99);
      #1;
      chk("post_rel_wr", a0, 32'h99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
